// File: rtl/replay_pkg.sv
// replay_pkg: shared state encoding, default widths and mask helper for the replay index sampler.
package replay_pkg;
  localparam int DEF_LFSR_W = 16;
  localparam int DEF_ADDR_W = 10;
  typedef enum logic [1:0] {SEED, IDLE, DRAW, HOLD} state_t;
  function automatic logic [DEF_ADDR_W-1:0] next_pow2_mask(input logic [DEF_ADDR_W:0] count);
    logic [DEF_ADDR_W:0] m;
    m = count - 1'b1;
    for (int i = 0; i < DEF_ADDR_W; i++) m = m | (m >> 1);
    return m[DEF_ADDR_W-1:0];
  endfunction
endpackage

// File: rtl/rs_mask_gen.sv
// rs_mask_gen: fill_count -> (next power of two - 1) mask via leading-one smear of count-1.
module rs_mask_gen
  import replay_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] mask
);
  logic [ADDR_W-1:0] m;
  logic hit;
  always_comb begin
    m = count[ADDR_W-1:0] - 1'b1;
    hit = 1'b0;
    mask = '0;
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      hit = hit | m[i];
      mask[i] = hit | count[ADDR_W];
    end
  end
endmodule

// File: rtl/replay_index_sampler.sv
// replay_index_sampler: seeds the replay LFSR and turns its output into uniform indices in [0, fill_count).
// Define SAMPLER_STATS_EN to add saturating reject_cnt / fallback_cnt outputs.
module replay_index_sampler
  import replay_pkg::*;
#(
  parameter int LFSR_W = DEF_LFSR_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int MAX_TRIES = 8,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_valid,
  input  logic [LFSR_W-1:0] seed,
  output logic              lfsr_we,
  output logic [LFSR_W-1:0] lfsr_data,
  input  logic [LFSR_W-1:0] lfsr_q,
  input  logic [ADDR_W:0]   fill_count,
  input  logic              req_valid,
  output logic              req_ready,
  output logic              idx_valid,
  output logic [ADDR_W-1:0] idx,
  input  logic              idx_ready
`ifdef SAMPLER_STATS_EN
  ,
  output logic [31:0]       reject_cnt,
  output logic [15:0]       fallback_cnt
`endif
);
  localparam int TW = $clog2(MAX_TRIES + 1);
  state_t state, next;
  logic [TW-1:0] tries;
  logic [ADDR_W:0] snapshot;
  logic [ADDR_W-1:0] mask, new_mask, cand;
  logic [LFSR_W-1:0] load_val;
  logic accept, hit, last, unused_hi;
  rs_mask_gen #(.ADDR_W(ADDR_W)) u_mask (.count(fill_count), .mask(new_mask));
  assign unused_hi = ^lfsr_q[LFSR_W-1:ADDR_W];
  assign cand = lfsr_q[ADDR_W-1:0] & mask;
  assign hit = {1'b0, cand} < snapshot;
  assign last = tries == TW'(MAX_TRIES - 1);
  assign accept = req_valid && req_ready;
  always_ff @(posedge clk) begin
    if (rst) state <= SEED;
    else state <= next;
  end
  always_comb begin
    next = state;
    unique case (state)
      SEED: next = IDLE;
      IDLE: next = accept ? DRAW : IDLE;
      DRAW: next = (hit || last) ? HOLD : DRAW;
      HOLD: next = idx_ready ? IDLE : HOLD;
    endcase
  end
  // outputs are forced low while rst is held so reset looks quiet to the LFSR and requester
  always_comb begin
    lfsr_we = !rst && (state == SEED || (state == IDLE && seed_valid));
    load_val = seed_valid ? seed : DEFAULT_SEED;
    lfsr_data = !lfsr_we ? '0 : (load_val == '0 ? LFSR_W'(1) : load_val);
    req_ready = !rst && state == IDLE && fill_count != '0 && !seed_valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tries <= '0;
      snapshot <= '0;
      mask <= '0;
      idx <= '0;
      idx_valid <= 1'b0;
    end else begin
      if (accept) begin
        snapshot <= fill_count;
        mask <= new_mask;
        tries <= '0;
      end
      if (state == DRAW) begin
        if (hit || last) begin
          idx <= hit ? cand : cand >> 1;
          idx_valid <= 1'b1;
        end else tries <= tries + 1'b1;
      end
      if (state == HOLD && idx_ready) idx_valid <= 1'b0;
    end
  end
`ifdef SAMPLER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      reject_cnt <= '0;
      fallback_cnt <= '0;
    end else if (state == DRAW && !hit) begin
      if (!(&reject_cnt)) reject_cnt <= reject_cnt + 1'b1;
      if (last && !(&fallback_cnt)) fallback_cnt <= fallback_cnt + 1'b1;
    end
  end
`endif
endmodule
